// File: rtl/gpr_wb_arbiter.sv
// GPR write-port arbiter for the WB stage: merges in-order LSU->WB pipeline
// results with out-of-order mul/div results held in a one-entry buffer.
// The pipeline wins by default; a starvation counter stalls it for one cycle
// so a buffered mul/div result never waits longer than STARVE_LIMIT+1 cycles.
module gpr_wb_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ls_valid,
    input  logic        ls_wen,
    input  logic [4:0]  ls_rd,
    input  logic [63:0] ls_data,
    output logic        ls_ready,
    input  logic        md_valid,
    input  logic [4:0]  md_rd,
    input  logic [63:0] md_data,
    output logic        md_ready,
    output logic        gpr_wen,
    output logic [4:0]  gpr_rd,
    output logic [63:0] gpr_wdata,
    output logic        md_pend_valid,
    output logic [4:0]  md_pend_rd
);

    logic             buf_valid;
    logic [4:0]       buf_rd;
    logic [63:0]      buf_data;
    logic [CNT_W-1:0] starve_cnt;

    logic stall;
    logic l_req;
    logic grant_b;
    logic md_load;

    // Handshakes depend on state only, so no input-to-ready paths exist.
    assign stall    = buf_valid && (starve_cnt == CNT_W'(STARVE_LIMIT));
    assign ls_ready = !stall;
    assign md_ready = !buf_valid;

    // Writes to x0 are architecturally dropped, so they never contest the port.
    assign l_req   = ls_valid && ls_ready && ls_wen && (ls_rd != 5'd0);
    assign grant_b = buf_valid && !l_req;
    assign md_load = md_valid && md_ready && (md_rd != 5'd0);

    // The scoreboard sees exactly the buffered entry, straight from its flops.
    assign md_pend_valid = buf_valid;
    assign md_pend_rd    = buf_rd;

    // Mul/div buffer: loads only when empty, drains when granted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_valid <= 1'b0;
            buf_rd    <= 5'd0;
            buf_data  <= 64'd0;
        end else if (md_load) begin
            buf_valid <= 1'b1;
            buf_rd    <= md_rd;
            buf_data  <= md_data;
        end else if (grant_b) begin
            buf_valid <= 1'b0;
        end
    end

    // Counts consecutive pipeline wins against a waiting buffered result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (!buf_valid || grant_b) begin
            starve_cnt <= '0;
        end else if (l_req && (starve_cnt != CNT_W'(STARVE_LIMIT))) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end

    // Registered GPR write port; index and data hold when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gpr_wen   <= 1'b0;
            gpr_rd    <= 5'd0;
            gpr_wdata <= 64'd0;
        end else if (l_req) begin
            gpr_wen   <= 1'b1;
            gpr_rd    <= ls_rd;
            gpr_wdata <= ls_data;
        end else if (grant_b) begin
            gpr_wen   <= 1'b1;
            gpr_rd    <= buf_rd;
            gpr_wdata <= buf_data;
        end else begin
            gpr_wen   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Bench for gpr_wb_arbiter: directed scenarios followed by random traffic,
// all compared against a transaction-level model of the write-port rules.
module tb_gpr_wb_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ls_valid = 1'b0, ls_wen = 1'b0;
    logic [4:0]  ls_rd = 5'd0;
    logic [63:0] ls_data = 64'd0;
    logic        ls_ready;
    logic        md_valid = 1'b0;
    logic [4:0]  md_rd = 5'd0;
    logic [63:0] md_data = 64'd0;
    logic        md_ready;
    logic        gpr_wen;
    logic [4:0]  gpr_rd;
    logic [63:0] gpr_wdata;
    logic        md_pend_valid;
    logic [4:0]  md_pend_rd;

    int n_cmp = 0;
    int n_err = 0;

    gpr_wb_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .ls_valid(ls_valid), .ls_wen(ls_wen), .ls_rd(ls_rd), .ls_data(ls_data),
        .ls_ready(ls_ready),
        .md_valid(md_valid), .md_rd(md_rd), .md_data(md_data), .md_ready(md_ready),
        .gpr_wen(gpr_wen), .gpr_rd(gpr_rd), .gpr_wdata(gpr_wdata),
        .md_pend_valid(md_pend_valid), .md_pend_rd(md_pend_rd)
    );

    always #5 clk = ~clk;

    // Reference model: pending mul/div results as a queue, plus how many
    // consecutive times the head has lost to the pipeline.
    typedef struct packed { logic [4:0] rd; logic [63:0] data; } md_res_t;
    md_res_t     m_q[$];
    int          m_loss = 0;
    logic        m_wen = 1'b0;
    logic [4:0]  m_rd = 5'd0;
    logic [63:0] m_data = 64'd0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_stall();
        return (m_q.size() != 0) && (m_loss >= LIMIT);
    endfunction

    task automatic m_reset();
        m_q.delete();
        m_loss = 0;
        m_wen  = 1'b0;
        m_rd   = 5'd0;
        m_data = 64'd0;
    endtask

    // One clock: check state-derived outputs, advance model, check write port.
    task automatic cyc();
        bit      l_win;
        bit      was_empty;
        md_res_t r;
        chk("ls_ready", ls_ready, !m_stall());
        chk("md_ready", md_ready, m_q.size() == 0);
        chk("pend_valid", md_pend_valid, m_q.size() != 0);
        if (m_q.size() != 0) chk("pend_rd", md_pend_rd, m_q[0].rd);
        was_empty = (m_q.size() == 0);
        l_win = ls_valid && !m_stall() && ls_wen && (ls_rd != 0);
        if (l_win) begin
            m_wen = 1'b1; m_rd = ls_rd; m_data = ls_data;
            if (!was_empty && m_loss < LIMIT) m_loss++;
        end else if (!was_empty) begin
            r = m_q.pop_front();
            m_wen = 1'b1; m_rd = r.rd; m_data = r.data;
            m_loss = 0;
        end else begin
            m_wen = 1'b0;
        end
        if (md_valid && was_empty && md_rd != 0) begin
            r.rd = md_rd; r.data = md_data;
            m_q.push_back(r);
            m_loss = 0;
        end
        @(posedge clk); #1;
        chk("gpr_wen", gpr_wen, m_wen);
        chk("gpr_rd", gpr_rd, m_rd);
        chk("gpr_wdata", gpr_wdata, m_data);
    endtask

    task automatic idle_in();
        ls_valid = 0; ls_wen = 0; ls_rd = 0; ls_data = 0;
        md_valid = 0; md_rd = 0; md_data = 0;
    endtask

    initial begin
        // Reset and idle
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        cyc(); cyc();
        chk("idle_wen", gpr_wen, 1'b0);
        chk("idle_md_ready", md_ready, 1'b1);
        chk("idle_ls_ready", ls_ready, 1'b1);

        // Lone pipeline write
        ls_valid = 1; ls_wen = 1; ls_rd = 5; ls_data = 64'hAA;
        cyc();
        chk("ls_only_wen", gpr_wen, 1'b1);
        chk("ls_only_rd", gpr_rd, 5'd5);
        chk("ls_only_data", gpr_wdata, 64'hAA);
        idle_in();

        // Lone mul/div result: buffer, then write, then ready again
        md_valid = 1; md_rd = 7; md_data = 64'h1234;
        cyc();
        idle_in();
        chk("md_buf_pend", md_pend_valid, 1'b1);
        chk("md_buf_rd", md_pend_rd, 5'd7);
        chk("md_buf_noready", md_ready, 1'b0);
        cyc();
        chk("md_wr_wen", gpr_wen, 1'b1);
        chk("md_wr_rd", gpr_rd, 5'd7);
        chk("md_wr_data", gpr_wdata, 64'h1234);
        chk("md_ready_back", md_ready, 1'b1);

        // Starvation: LIMIT pipeline wins, one stall, then buffered write
        md_valid = 1; md_rd = 9; md_data = 64'h99;
        cyc();
        idle_in();
        ls_valid = 1; ls_wen = 1; ls_rd = 3;
        for (int i = 0; i < LIMIT; i++) begin
            ls_data = {$urandom, $urandom};
            chk("starve_ready", ls_ready, 1'b1);
            cyc();
            chk("starve_ls_rd", gpr_rd, 5'd3);
        end
        chk("starve_stall", ls_ready, 1'b0);
        cyc();
        chk("starve_md_rd", gpr_rd, 5'd9);
        chk("starve_md_data", gpr_wdata, 64'h99);
        chk("starve_cnt_clr", dut.starve_cnt, 8'd0);
        chk("starve_release", ls_ready, 1'b1);
        idle_in();

        // Result to x0 is swallowed
        md_valid = 1; md_rd = 0; md_data = 64'hDEAD;
        cyc();
        idle_in();
        chk("x0_md_ready", md_ready, 1'b1);
        chk("x0_pend", md_pend_valid, 1'b0);
        chk("x0_nowr", gpr_wen, 1'b0);

        // Non-writing pipeline instruction lets the buffer through
        md_valid = 1; md_rd = 12; md_data = 64'hC0FFEE;
        cyc();
        idle_in();
        ls_valid = 1; ls_wen = 0; ls_rd = 4; ls_data = 64'h4444;
        cyc();
        chk("nowen_b_rd", gpr_rd, 5'd12);
        chk("nowen_b_wen", gpr_wen, 1'b1);
        idle_in();
        cyc();

        // Reset while a result is buffered: it is lost
        md_valid = 1; md_rd = 15; md_data = 64'h1515;
        cyc();
        idle_in();
        chk("rst_pre_pend", md_pend_valid, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("rst_pend", md_pend_valid, 1'b0);
        chk("rst_wen", gpr_wen, 1'b0);
        chk("rst_md_ready", md_ready, 1'b1);
        m_reset();
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("rst_lost", gpr_wen, 1'b0);
        end

        // Random traffic against the model
        for (int i = 0; i < 500; i++) begin
            ls_valid = ($urandom_range(0, 3) != 0);
            ls_wen   = ($urandom_range(0, 7) != 0);
            ls_rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            ls_data  = {$urandom, $urandom};
            md_valid = ($urandom_range(0, 2) == 0);
            md_rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            md_data  = {$urandom, $urandom};
            cyc();
        end
        idle_in();
        cyc(); cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
